// File: rtl/bus_pkg.sv
// Shared definitions for the external bus arbiter: bus-cycle state codes,
// direction and port encodings, and default bus widths.
package bus_pkg;

  localparam int DEF_ADDR_W = 20;
  localparam int DEF_DATA_W = 16;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam logic PORT_IQ = 1'b0;
  localparam logic PORT_EU = 1'b1;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_T1   = 2'd1;
  localparam state_t ST_T2   = 2'd2;
  localparam state_t ST_T3   = 2'd3;

  // True for the bus-cycle phases in which the data strobe is driven.
  function automatic logic is_data_phase(input state_t s);
    return (s == ST_T2) || (s == ST_T3);
  endfunction

endpackage

// File: rtl/io_bus_arbiter.sv
// Two-port external bus arbiter. The execution engine (port 1) beats the
// instruction queue (port 0) on a tie, the port acked this cycle sits out
// this cycle's arbitration, and each grant runs one T1/T2/T3 bus cycle with
// bounded wait states. Every output is a flop.
module io_bus_arbiter
  import bus_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int WAIT_MAX = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              rw0,
  input  logic              rw1,
  input  logic [ADDR_W-1:0] adr0,
  input  logic [ADDR_W-1:0] adr1,
  input  logic [DATA_W-1:0] dtw0,
  input  logic [DATA_W-1:0] dtw1,
  output logic [DATA_W-1:0] dtr0,
  output logic [DATA_W-1:0] dtr1,
  output logic              ack0,
  output logic              ack1,
  output logic              err0,
  output logic              err1,
  output logic [ADDR_W-1:0] bus_adr,
  output logic [DATA_W-1:0] bus_dout,
  input  logic [DATA_W-1:0] bus_din,
  output logic              bus_rw,
  output logic              bus_as,
  output logic              bus_ds,
  input  logic              bus_rdy,
  output logic              busy,
  output logic              owner
);

  localparam int CW = $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] WAIT_LIM = CW'(WAIT_MAX);

  state_t        state;
  state_t        nxt_state;
  logic [CW-1:0] wait_cnt;

  logic elig0;
  logic elig1;
  logic grant;
  logic grant_port;
  logic at_limit;
  logic done;
  logic abort;
  logic read_done;

  // The registered ack keeps the port just served out of this IDLE cycle,
  // which is what makes back-to-back requesters alternate.
  assign elig0      = req0 & ~ack0;
  assign elig1      = req1 & ~ack1;
  assign grant      = (state == ST_IDLE) && (elig0 || elig1);
  assign grant_port = elig1 ? PORT_EU : PORT_IQ;

  assign at_limit  = (wait_cnt == WAIT_LIM);
  assign done      = (state == ST_T3) && (bus_rdy || at_limit);
  assign abort     = (state == ST_T3) && !bus_rdy && at_limit;
  assign read_done = (state == ST_T3) && bus_rdy && (bus_rw == RW_READ);

  // Bus-cycle sequencing: IDLE waits for a grant, T1 and T2 always advance,
  // T3 repeats as a wait state until the target is ready or patience runs out.
  always_comb begin
    nxt_state = state;
    case (state)
      ST_IDLE: if (grant) nxt_state = ST_T1;
      ST_T1:   nxt_state = ST_T2;
      ST_T2:   nxt_state = ST_T3;
      ST_T3:   if (done) nxt_state = ST_IDLE;
      default: nxt_state = ST_IDLE;
    endcase
  end

  // State register and the wait-state counter, which only runs while T3 is stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      state <= nxt_state;
      if ((state == ST_T3) && !done)
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;
    end
  end

  // Capture the winner's address, direction and write data at grant so the
  // requester may change or drop its inputs for the rest of the cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus_adr  <= '0;
      bus_dout <= '0;
      bus_rw   <= RW_READ;
      owner    <= PORT_IQ;
    end else if (grant) begin
      owner <= grant_port;
      if (grant_port == PORT_EU) begin
        bus_adr  <= adr1;
        bus_dout <= dtw1;
        bus_rw   <= rw1;
      end else begin
        bus_adr  <= adr0;
        bus_dout <= dtw0;
        bus_rw   <= rw0;
      end
    end
  end

  // Strobes and busy follow the phase being entered, so they line up with the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus_as <= 1'b0;
      bus_ds <= 1'b0;
      busy   <= 1'b0;
    end else begin
      bus_as <= (nxt_state == ST_T1);
      bus_ds <= is_data_phase(nxt_state);
      busy   <= (nxt_state != ST_IDLE);
    end
  end

  // One-cycle completion pulses to the owner; err rides along when T3 gave up.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      err0 <= 1'b0;
      err1 <= 1'b0;
    end else begin
      ack0 <= done && (owner == PORT_IQ);
      ack1 <= done && (owner == PORT_EU);
      err0 <= abort && (owner == PORT_IQ);
      err1 <= abort && (owner == PORT_EU);
    end
  end

  // Read data is captured only on a successful read and only into the owner's register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dtr0 <= '0;
      dtr1 <= '0;
    end else if (read_done) begin
      if (owner == PORT_EU)
        dtr1 <= bus_din;
      else
        dtr0 <= bus_din;
    end
  end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter. Stimulus pushes hand-computed ack
// expectations into a scoreboard; a negedge monitor pops one per ack and
// compares cycle, port, err, read data and latched address.
module tb_io_bus_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0, req1;
  logic        rw0, rw1;
  logic [19:0] adr0, adr1;
  logic [15:0] dtw0, dtw1;
  logic [15:0] dtr0, dtr1;
  logic        ack0, ack1;
  logic        err0, err1;
  logic [19:0] bus_adr;
  logic [15:0] bus_dout;
  logic [15:0] bus_din;
  logic        bus_rw;
  logic        bus_as;
  logic        bus_ds;
  logic        bus_rdy;
  logic        busy;
  logic        owner;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  typedef struct {
    int          cyc;
    logic        port;
    logic        err;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [19:0] adr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   b;
  int   b2;

  io_bus_arbiter #(.ADDR_W(20), .DATA_W(16), .WAIT_MAX(7)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
    .adr0(adr0), .adr1(adr1), .dtw0(dtw0), .dtw1(dtw1),
    .dtr0(dtr0), .dtr1(dtr1), .ack0(ack0), .ack1(ack1),
    .err0(err0), .err1(err1),
    .bus_adr(bus_adr), .bus_dout(bus_dout), .bus_din(bus_din),
    .bus_rw(bus_rw), .bus_as(bus_as), .bus_ds(bus_ds), .bus_rdy(bus_rdy),
    .busy(busy), .owner(owner)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index: value seen at a negedge is the number of rising edges so far.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void expect_ack(input int c, input logic p, input logic e,
                                     input logic [15:0] d0, input logic [15:0] d1,
                                     input logic [19:0] a);
    exp_t x;
    x.cyc = c; x.port = p; x.err = e; x.d0 = d0; x.d1 = d1; x.adr = a;
    sb.push_back(x);
  endfunction

  // Scoreboard monitor: every ack consumes one expectation; an overdue
  // expectation with no ack is reported as missing.
  always @(negedge clk) begin
    if (ack0 || ack1) begin
      if (sb.size() == 0) begin
        check_output("unexpected_ack", {30'd0, ack1, ack0}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check_output("ack_cycle", cyc, mon_e.cyc);
        check_output("ack_port", {30'd0, ack1, ack0}, mon_e.port ? 32'd2 : 32'd1);
        check_output("err_pair", {30'd0, err1, err0}, !mon_e.err ? 32'd0 : (mon_e.port ? 32'd2 : 32'd1));
        check_output("dtr0", dtr0, mon_e.d0);
        check_output("dtr1", dtr1, mon_e.d1);
        check_output("ack_bus_adr", bus_adr, mon_e.adr);
      end
    end else begin
      if (err0 || err1)
        check_output("err_without_ack", {30'd0, err1, err0}, 32'd0);
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        check_output("missing_ack", {30'd0, ack1, ack0}, sb[0].port ? 32'd2 : 32'd1);
        void'(sb.pop_front());
      end
    end
  end

  task automatic apply_stimulus(input logic port, input logic rq, input logic rw,
                                input logic [19:0] adr, input logic [15:0] dtw);
    if (port) begin
      req1 = rq; rw1 = rw; adr1 = adr; dtw1 = dtw;
    end else begin
      req0 = rq; rw0 = rw; adr0 = adr; dtw0 = dtw;
    end
  endtask

  task automatic check_reset_values();
    check_output("rst_ack0", ack0, 0);
    check_output("rst_ack1", ack1, 0);
    check_output("rst_err0", err0, 0);
    check_output("rst_err1", err1, 0);
    check_output("rst_bus_as", bus_as, 0);
    check_output("rst_bus_ds", bus_ds, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_owner", owner, 0);
    check_output("rst_bus_adr", bus_adr, 0);
    check_output("rst_bus_dout", bus_dout, 0);
    check_output("rst_dtr0", dtr0, 0);
    check_output("rst_dtr1", dtr1, 0);
    check_output("rst_bus_rw", bus_rw, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    req0 = 0; req1 = 0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    check_reset_values();
    rst_n = 1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 64 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      check_output("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Hard stop in case anything hangs.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 0; req0 = 0; req1 = 0; rw0 = 1; rw1 = 1;
    adr0 = '0; adr1 = '0; dtw0 = '0; dtw1 = '0;
    bus_din = '0; bus_rdy = 1;

    $display("[TB] test 1: both ports read, port 1 first, then alternating");
    do_reset();
    b = cyc;
    apply_stimulus(0, 1, 1, 20'h00002, 16'h0);
    apply_stimulus(1, 1, 1, 20'h00004, 16'h0);
    bus_din = 16'h0011;
    expect_ack(b + 4,  1, 0, 16'h0000, 16'h0011, 20'h00004);
    expect_ack(b + 8,  0, 0, 16'h0011, 16'h0011, 20'h00002);
    expect_ack(b + 12, 1, 0, 16'h0011, 16'h0011, 20'h00004);
    expect_ack(b + 16, 0, 0, 16'h0011, 16'h0011, 20'h00002);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check_output("t1_first_adr", bus_adr, 20'h00004);
        check_output("t1_first_owner", owner, 1);
        check_output("t1_first_as", bus_as, 1);
      end
      if (k == 5) begin
        check_output("t1_second_adr", bus_adr, 20'h00002);
        check_output("t1_second_owner", owner, 0);
      end
      if (k == 14) begin
        req0 = 0; req1 = 0;
      end
    end
    wait_drain();

    $display("[TB] test 2: single port read, re-grant one cycle after ack");
    do_reset();
    b = cyc;
    apply_stimulus(1, 1, 1, 20'h00100, 16'h0);
    bus_din = 16'hBEEF;
    expect_ack(b + 4, 1, 0, 16'h0000, 16'hBEEF, 20'h00100);
    expect_ack(b + 9, 1, 0, 16'h0000, 16'hCAFE, 20'h00100);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 4) check_output("t2_ack_cycle_idle", busy, 0);
      if (k == 5) begin
        check_output("t2_excluded_cycle_idle", busy, 0);
        bus_din = 16'hCAFE;
      end
      if (k == 6) begin
        check_output("t2_regrant_busy", busy, 1);
        check_output("t2_regrant_as", bus_as, 1);
      end
      if (k == 7) req1 = 0;
    end
    wait_drain();

    $display("[TB] test 3: port 0 read then port 0 write");
    do_reset();
    b = cyc;
    apply_stimulus(0, 1, 1, 20'h00010, 16'h0);
    bus_din = 16'h5555;
    expect_ack(b + 4, 0, 0, 16'h5555, 16'h0000, 20'h00010);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) req0 = 0;
    end
    b2 = cyc;
    apply_stimulus(0, 1, 0, 20'hABCDE, 16'h1234);
    bus_din = 16'h7777;
    expect_ack(b2 + 4, 0, 0, 16'h5555, 16'h0000, 20'hABCDE);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check_output("t3_T1_as", bus_as, 1);
        check_output("t3_T1_ds", bus_ds, 0);
        check_output("t3_T1_busy", busy, 1);
        check_output("t3_T1_rw", bus_rw, 0);
        check_output("t3_T1_adr", bus_adr, 20'hABCDE);
        check_output("t3_T1_dout", bus_dout, 16'h1234);
        check_output("t3_T1_owner", owner, 0);
        req0 = 0;
      end
      if (k == 2) begin
        check_output("t3_T2_as", bus_as, 0);
        check_output("t3_T2_ds", bus_ds, 1);
        check_output("t3_T2_rw", bus_rw, 0);
        check_output("t3_T2_dout", bus_dout, 16'h1234);
      end
      if (k == 3) begin
        check_output("t3_T3_as", bus_as, 0);
        check_output("t3_T3_ds", bus_ds, 1);
      end
      if (k == 4) begin
        check_output("t3_idle_ds", bus_ds, 0);
        check_output("t3_idle_busy", busy, 0);
      end
    end
    wait_drain();

    $display("[TB] test 4: two wait states, then a full abort");
    do_reset();
    b = cyc;
    apply_stimulus(1, 1, 1, 20'h00200, 16'h0);
    bus_din = 16'h1111;
    bus_rdy = 0;
    expect_ack(b + 6, 1, 0, 16'h0000, 16'h1111, 20'h00200);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) req1 = 0;
      if (k == 4) begin
        check_output("t4_wait_ds", bus_ds, 1);
        check_output("t4_wait_as", bus_as, 0);
        check_output("t4_wait_busy", busy, 1);
      end
      if (k == 5) bus_rdy = 1;
    end
    wait_drain();
    b = cyc;
    apply_stimulus(0, 1, 1, 20'h00300, 16'h0);
    bus_din = 16'h2222;
    bus_rdy = 0;
    expect_ack(b + 11, 0, 1, 16'h0000, 16'h1111, 20'h00300);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) req0 = 0;
      if (k == 10) begin
        check_output("t4_last_wait_ds", bus_ds, 1);
        check_output("t4_last_wait_busy", busy, 1);
      end
      if (k == 12) bus_rdy = 1;
    end
    wait_drain();

    $display("[TB] test 5: reset during T2, held request re-granted");
    do_reset();
    b = cyc;
    apply_stimulus(1, 1, 1, 20'h00400, 16'h0);
    bus_din = 16'h3333;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 2) begin
        check_output("t5_T2_ds", bus_ds, 1);
        rst_n = 0;
      end
      if (k == 3) begin
        check_reset_values();
        rst_n = 1;
        b2 = cyc;
        expect_ack(b2 + 4, 1, 0, 16'h0000, 16'h3333, 20'h00400);
      end
    end
    @(negedge clk);
    check_output("t5_regrant_as", bus_as, 1);
    req1 = 0;
    wait_drain();

    $display("[TB] test 6: request dropped and inputs changed during T2");
    do_reset();
    b = cyc;
    apply_stimulus(0, 1, 1, 20'h12345, 16'h0);
    bus_din = 16'h4444;
    expect_ack(b + 4, 0, 0, 16'h4444, 16'h0000, 20'h12345);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 2) apply_stimulus(0, 0, 0, 20'h54321, 16'hFFFF);
      if (k == 3) begin
        check_output("t6_held_adr", bus_adr, 20'h12345);
        check_output("t6_held_rw", bus_rw, 1);
        check_output("t6_held_dout", bus_dout, 16'h0000);
      end
      if (k == 8) begin
        check_output("t6_no_regrant_busy", busy, 0);
        check_output("t6_no_regrant_adr", bus_adr, 20'h12345);
      end
    end
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/io_bus_arbiter.md
# io_bus_arbiter

Arbitrates the CPU's single external bus between the instruction queue (port 0) and the execution engine (port 1), then sequences each granted transfer as a fixed T1/T2/T3 bus cycle with optional wait states. It sits between the two requesters and the memory/IO pins and latches address, direction and write data at grant. It returns read data and a one-cycle acknowledge to the winning port.

## Interface
- ADDR_W, 20, bus address width
- DATA_W, 16, bus data width
- WAIT_MAX, 7, wait cycles tolerated in T3 before abort (1..255)
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- req0 / req1  in  1  transfer request, port 0 (instruction queue) / port 1 (execution engine)
- rw0 / rw1  in  1  1 = read, 0 = write
- adr0 / adr1  in  ADDR_W  transfer address
- dtw0 / dtw1  in  DATA_W  write data
- dtr0 / dtr1  out  DATA_W  read data, valid when ack high
- ack0 / ack1  out  1  one-cycle completion pulse
- err0 / err1  out  1  one-cycle abort pulse, coincident with ack
- bus_adr  out  ADDR_W  latched address
- bus_dout  out  DATA_W  latched write data
- bus_din  in  DATA_W  read data from the bus
- bus_rw  out  1  latched direction
- bus_as  out  1  address strobe, high in T1 only
- bus_ds  out  1  data strobe, high in T2, T3 and wait states
- bus_rdy  in  1  target ready, sampled in T3
- busy  out  1  high in T1/T2/T3
- owner  out  1  port of the current or last cycle

## Operation
- States: IDLE, T1, T2, T3. T3 repeats as a wait state while bus_rdy is 0.
- **IDLE arbitration.** If any eligible req is high, grant it and go to T1.
  - Port 1 wins when both ports request.
  - Grant latches adr/rw/dtw into bus_adr/bus_rw/bus_dout and sets owner.
  - Requester inputs are ignored until the next grant.
- **Ack-cycle exclusion.** The port acked in the current cycle is not eligible in that IDLE cycle.
  - When both ports hold req continuously, grants therefore alternate.
  - When a single port holds req alone, it is re-granted one cycle later.
- T1 → T2 → T3 unconditionally.
- **T3 with bus_rdy = 1.**
  - Read: dtr[owner] <= bus_din.
  - Next cycle: ack[owner] = 1, state = IDLE.
- **T3 with bus_rdy = 0.**
  - Increment the wait counter and stay in T3.
  - When the counter reaches WAIT_MAX with rdy still 0: next cycle ack[owner] = 1 and err[owner] = 1, dtr unchanged, state = IDLE.
- Dropping req mid-cycle does not cancel the transfer; the ack is still issued.
- dtr of the non-owning port never changes. Writes never change dtr.
- **Reset (rst_n = 0 at a clock edge, any state, mid-cycle included).**
  - State = IDLE and the cycle is aborted silently (no ack).
  - ack0/1, err0/1, bus_as, bus_ds, busy, owner, bus_adr, bus_dout, dtr0/1, wait counter all = 0.
  - bus_rw = 1.

## Timing
- Request sampled in IDLE at edge N. Then:
  - T1 in cycle N+1.
  - T2 in N+2.
  - T3 in N+3.
  - ack in N+4 (IDLE).
- Zero-wait throughput: one transfer per 4 cycles.
- Each wait state adds exactly 1 cycle.
- An abort acks WAIT_MAX+1 cycles after first entering T3.
- All outputs are registered; no combinational path from req or bus_rdy to any output.
- ack and err are high for exactly one cycle per granted transfer.

## Structure
- Shared package `bus_pkg`:
  - state enum (IDLE, T1, T2, T3)
  - RW_READ = 1, RW_WRITE = 0
  - ADDR_W/DATA_W defaults
  - PORT_IQ = 0, PORT_EU = 1
- No sub-module. The wait counter is sized $clog2(WAIT_MAX+1) and kept inline.

## Test plan
- **Both ports request a read from reset.** req0 = req1 = 1, adr0 = 2, adr1 = 4, bus_rdy = 1.
  - Port 1 is granted first: bus_adr = 4, ack1 at cycle 4.
  - Port 0 follows: bus_adr = 2, ack0 at cycle 8.
  - Grants then alternate.
- **Single-port read returns data.** req1 only, bus_din = 16'hBEEF.
  - dtr1 = 16'hBEEF with ack1 high.
  - dtr0 stays 0.
- **Write from port 0.** rw0 = 0, dtw0 = 16'h1234, adr0 = 20'hABCDE.
  - bus_dout = 16'h1234, bus_adr = 20'hABCDE, bus_rw = 0 through T1..T3.
  - bus_as high in T1 only; bus_ds high in T2..T3.
  - ack0 pulses; dtr0 unchanged.
- **Wait states then abort.**
  - bus_rdy low for 2 cycles in T3: ack arrives 2 cycles late, err = 0.
  - bus_rdy held low: ack and err pulse together after 8 T3 cycles (WAIT_MAX = 7).
- **Reset mid-cycle.** rst_n low during T2.
  - Next cycle: IDLE, every output at its reset value, no ack.
  - After release, a held req is granted normally.
- **Request dropped and inputs changed mid-cycle.** req0 dropped and adr0 changed during T2.
  - bus_adr keeps the latched value.
  - ack0 is still issued.
  - No new grant for port 0 afterwards.
